// File: rtl/spi_mnrch_pkg.sv
// Shared types and constants for the SPI monarch (state encoding, divider
// preload and the divider values at which MISO is sampled / data is shifted).
package spi_mnrch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    localparam int XFER_BITS = 16;
    localparam int BIT_CNT_W = 5;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 5'd16;

    // {2'b10, ones}: SCLK starts high and the first fall comes a few clk later
    function automatic int unsigned preload_val(input int unsigned div_w);
        return (32'd2 << (div_w - 32'd2)) | ((32'd1 << (div_w - 32'd2)) - 32'd1);
    endfunction

    // {0, ones}: the next increment raises SCLK
    function automatic int unsigned smpl_match(input int unsigned div_w);
        return (32'd1 << (div_w - 32'd1)) - 32'd1;
    endfunction

    // all ones: the next increment drops SCLK
    function automatic int unsigned shft_match(input int unsigned div_w);
        return (32'd1 << div_w) - 32'd1;
    endfunction

endpackage

// File: rtl/spi_mnrch_sclk_gen.sv
// SCLK divider for the SPI monarch. SCLK is the divider MSB; the strobes flag
// the clk edge at which SCLK will rise (sample) or fall (shift). hold_i keeps
// the divider parked at the preload value so SCLK idles high.
module spi_sclk_gen
    import spi_mnrch_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    output logic sclk_o,
    output logic smpl_o,
    output logic shft_o
);

    localparam logic [DIV_W-1:0] PRELOAD  = DIV_W'(preload_val(DIV_W));
    localparam logic [DIV_W-1:0] SMPL_VAL = DIV_W'(smpl_match(DIV_W));
    localparam logic [DIV_W-1:0] SHFT_VAL = DIV_W'(shft_match(DIV_W));

    logic [DIV_W-1:0] div_q;

    // Free-running divider, parked at the preload while held or in reset
    always_ff @(posedge clk) begin
        if (rst || hold_i) begin
            div_q <= PRELOAD;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign sclk_o = div_q[DIV_W-1];
    assign smpl_o = (div_q == SMPL_VAL);
    assign shft_o = (div_q == SHFT_VAL);

endmodule

// File: rtl/spi_mnrch.sv
// SPI mode-3 monarch: one 16-bit full-duplex transfer per wrt pulse.
// MOSI changes on SCLK fall, MISO is sampled on SCLK rise, rsp holds the
// received word while done is high.
// Optional build macro SPI_MNRCH_CMD_QUEUE_EN adds a one-entry command buffer
// that catches a wrt arriving while busy and launches it right after done.
module spi_mnrch
    import spi_mnrch_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rsp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    state_t                 state_q;
    logic [15:0]            shft_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   miso_smpl_q;
    logic                   ss_n_q;
    logic                   done_q;

    logic                   smpl_stb;
    logic                   shft_stb;
    logic                   sclk_hold;
    logic                   start_vld;
    logic [15:0]            start_cmd;

`ifdef SPI_MNRCH_CMD_QUEUE_EN
    logic                   q_vld_q;
    logic [15:0]            q_cmd_q;
`endif

    // Divider parks in IDLE and is reloaded on the final fall edge in BACK,
    // which cancels that fall so SCLK stays high after the transfer.
    assign sclk_hold = (state_q == IDLE) || ((state_q == BACK) && shft_stb);

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .hold_i (sclk_hold),
        .sclk_o (SCLK),
        .smpl_o (smpl_stb),
        .shft_o (shft_stb)
    );

    // Pick the command that starts a transfer from IDLE (a live wrt wins over a buffered one)
    always_comb begin
        start_vld = wrt;
        start_cmd = cmd;
`ifdef SPI_MNRCH_CMD_QUEUE_EN
        if (!wrt && q_vld_q) begin
            start_vld = 1'b1;
            start_cmd = q_cmd_q;
        end
`endif
    end

    // Transfer sequencer: select, first-fall skip, 16 sample/shift pairs, final shift
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shft_q      <= '0;
            bit_cnt_q   <= '0;
            miso_smpl_q <= 1'b0;
            ss_n_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef SPI_MNRCH_CMD_QUEUE_EN
            q_vld_q     <= 1'b0;
            q_cmd_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_vld) begin
                        shft_q    <= start_cmd;
                        ss_n_q    <= 1'b0;
                        done_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= FRONT;
`ifdef SPI_MNRCH_CMD_QUEUE_EN
                        q_vld_q   <= 1'b0;
`endif
                    end
                end
                FRONT: begin
                    // MOSI already shows cmd[15]; the first fall only aligns the bit
                    if (shft_stb) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (smpl_stb && (bit_cnt_q != LAST_BIT)) begin
                        miso_smpl_q <= MISO;
                        bit_cnt_q   <= bit_cnt_q + BIT_CNT_W'(1);
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q <= BACK;
                    end else if (shft_stb) begin
                        shft_q <= {shft_q[14:0], miso_smpl_q};
                    end
                end
                BACK: begin
                    if (shft_stb) begin
                        shft_q  <= {shft_q[14:0], miso_smpl_q};
                        ss_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef SPI_MNRCH_CMD_QUEUE_EN
            // A command arriving while busy is parked; a later one replaces it
            if (wrt && (state_q != IDLE)) begin
                q_vld_q <= 1'b1;
                q_cmd_q <= cmd;
            end
`endif
        end
    end

    assign MOSI = shft_q[15];
    assign rsp  = shft_q;
    assign SS_n = ss_n_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_mnrch.sv
// Bench for spi_mnrch: a small sensor-like serf model answers every transfer,
// a scoreboard queue holds expected {cmd, rsp} pairs and a monitor compares
// them whenever done rises; a second monitor checks SCLK/SS_n timing.
module tb_spi_mnrch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        done;
    logic [15:0] rsp;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] rsp;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    spi_mnrch #(.DIV_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt),
        .cmd  (cmd),
        .done (done),
        .rsp  (rsp),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- serf model ----------------
    // Upper response byte is a fixed header; lower byte is register data on a
    // read or 8'hA5 on a write. Writes land in regs after the 16th rise.
    logic [7:0]  regs [0:127];
    logic [7:0]  hdr = 8'h3C;
    logic [15:0] mosi_sh = 16'h0000;
    logic [7:0]  rd_byte = 8'h00;
    logic        miso_r = 1'b1;
    int          rises = 0;

    assign MISO = SS_n ? 1'b1 : miso_r;

    always @(negedge SS_n) begin
        rises   = 0;
        mosi_sh = 16'h0000;
        miso_r  = hdr[7];
    end

    always @(posedge SCLK) begin
        if (!SS_n) begin
            mosi_sh = {mosi_sh[14:0], MOSI};
            rises++;
            if (rises == 8) rd_byte = mosi_sh[7] ? regs[mosi_sh[6:0]] : 8'hA5;
            if (rises == 16 && !mosi_sh[15]) regs[mosi_sh[14:8]] = mosi_sh[7:0];
        end
    end

    always @(negedge SCLK) begin
        if (!SS_n && rises > 0 && rises < 16)
            miso_r = (rises < 8) ? hdr[7 - rises] : rd_byte[15 - rises];
    end

    // ---------------- scoreboard monitor ----------------
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with rsp %h, expected no transfer", rsp);
            end else begin
                mon_e = sb.pop_front();
                check16("rsp", rsp, mon_e.rsp);
                check16("mosi_bits", mosi_sh, mon_e.cmd);
                check16("ss_n_at_done", {15'b0, SS_n}, 16'h0001);
                check16("sclk_at_done", {15'b0, SCLK}, 16'h0001);
                $display("xfer cmd=%h rsp=%h expected=%h", mon_e.cmd, rsp, mon_e.rsp);
            end
        end
        done_prev = done;
    end

    // ---------------- timing monitor ----------------
    logic ss_prev = 1'b1;
    logic sclk_prev = 1'b1;
    int   ss_fall_cyc = 0, first_fall = -1, last_rise = 0, rise_cnt = 0, ss_falls = 0;
    bit   per_ok = 1'b1;
    always @(negedge clk) begin
        if (ss_prev && !SS_n) begin
            ss_fall_cyc = cyc;
            first_fall  = -1;
            rise_cnt    = 0;
            per_ok      = 1'b1;
            ss_falls++;
        end
        if (!SS_n && sclk_prev && !SCLK && first_fall < 0) first_fall = cyc;
        if (!sclk_prev && SCLK) begin
            if (SS_n) begin
                if (!rst) begin
                    checks++;
                    errors++;
                    $display("FAIL sclk_rise_while_deselected: got rise at cyc %0d, expected none", cyc);
                end
            end else begin
                if (rise_cnt > 0 && (cyc - last_rise) != 16) per_ok = 1'b0;
                rise_cnt++;
                last_rise = cyc;
            end
        end
        if (!ss_prev && SS_n && done) begin
            checkint("sclk_rises", rise_cnt, 16);
            checkint("ssn_to_first_fall", first_fall - ss_fall_cyc, 5);
            checkint("last_rise_to_ssn", cyc - last_rise, 8);
            checkint("sclk_period_16", int'(per_ok), 1);
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [15:0] c, input logic [15:0] r);
        @(negedge clk);
        wrt = 1'b1;
        cmd = c;
        sb.push_back('{c, r});
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d clk, expected done=1", n);
        end
    endtask

    task automatic run(input logic [15:0] c, input logic [15:0] r);
        issue(c, r);
        wait_done();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int falls0;
        int w;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        regs[7'h0F] = 8'h6A;
        regs[7'h22] = 8'h5A;
        regs[7'h23] = 8'hC3;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check16("reset_ss_n", {15'b0, SS_n}, 16'h0001);
        check16("reset_sclk", {15'b0, SCLK}, 16'h0001);
        check16("reset_done", {15'b0, done}, 16'h0000);
        check16("reset_rsp", rsp, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(16'h8F00, 16'h3C6A);   // read WHO_AM_I
        run(16'h0D02, 16'h3CA5);   // write 0x0D
        run(16'h1160, 16'h3CA5);   // write 0x11
        run(16'h8D00, 16'h3C02);   // read back 0x0D
        run(16'hA200, 16'h3C5A);   // read 0x22
        run(16'hA300, 16'h3CC3);   // read 0x23

        // reset in the middle of a transfer
        issue(16'h8F00, 16'h3C6A);
        repeat (98) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check16("midreset_ss_n", {15'b0, SS_n}, 16'h0001);
        check16("midreset_sclk", {15'b0, SCLK}, 16'h0001);
        check16("midreset_done", {15'b0, done}, 16'h0000);
        check16("midreset_rsp", rsp, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(16'h8F00, 16'h3C6A);

        // wrt while busy
        falls0 = ss_falls;
        issue(16'h8F00, 16'h3C6A);
        repeat (48) @(negedge clk);
        wrt = 1'b1;
        cmd = 16'h9100;
`ifdef SPI_MNRCH_CMD_QUEUE_EN
        sb.push_back('{16'h9100, 16'h3C60});
`endif
        @(negedge clk);
        wrt = 1'b0;
        wait_done();
`ifdef SPI_MNRCH_CMD_QUEUE_EN
        w = 0;
        while (done && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkint("queued_done_width", w, 1);
        wait_done();
        repeat (4) @(negedge clk);
        checkint("ss_n_fall_count", ss_falls - falls0, 2);
`else
        w = 0;
        repeat (300) @(negedge clk);
        checkint("ss_n_fall_count", ss_falls - falls0, 1);
`endif

        checkint("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
